input_arbiter: RTL and testbench
================================

INPUT_ARBITER -- requirements
Module: input_arbiter

Interface
REQ-001 Parameter DAS_TICKS, default 8: input ticks a held repeatable button must stay high before its first auto-repeat; legal range 1..15.
REQ-002 Parameter ARR_TICKS, default 2: input ticks between later auto-repeats; legal range 1..15.
REQ-003 clock  input  1  board clock (CLOCK_50 domain); all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_input  input  1  one-clock input pacing strobe.
REQ-006 btn_edge  input  5  one-clock press pulses, already synchronized, debounced and edge-detected; bit index = button ID.
REQ-007 btn_level  input  5  debounced button levels; bit index = button ID.
REQ-008 cmd_ready  input  1  game logic accepts the command in this cycle.
REQ-009 cmd_valid  output  1  a command is being offered.
REQ-010 cmd_code  output  3  command encoding; see REQ-013.
REQ-011 pending  output  5  per-button pending flags, for debug and the bench.

Function
REQ-012 Button IDs: 0 LEFT, 1 RIGHT, 2 ROTATE, 3 DOWN, 4 DROP.
REQ-013 cmd_code values: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DOWN, 5 DROP; 6 and 7 are never driven.
REQ-014 pending[i] sets on btn_edge[i] or on an auto-repeat request from button i; it clears only when button i is granted.
REQ-015 If a set and a grant clear hit the same pending bit in the same cycle, the set wins and the bit stays 1.
REQ-016 Grant condition: tick_input=1, cmd_valid=0 (or cmd_valid=1 with cmd_ready=1 in that cycle), and pending is non-zero.
REQ-017 Grant priority is fixed: DROP > ROTATE > LEFT > RIGHT > DOWN; exactly one button is granted per grant.
REQ-018 Exception: if LEFT and RIGHT are both pending and neither is higher-priority than the winner, both flags clear and neither is granted (they cancel). If a lower-priority button is pending, it is granted in that same cycle.
REQ-019 Grant latency: cmd_valid=1 and cmd_code are registered and appear in the cycle after the granting tick.
REQ-020 While cmd_valid=1 and cmd_ready=0, cmd_valid and cmd_code hold stable; ticks in that period grant nothing, and the pending flags are kept.
REQ-021 With cmd_valid=1 and cmd_ready=1 and no grant in the same cycle, cmd_valid drops to 0 and cmd_code drops to 0 on the next cycle.
REQ-022 Auto-repeat applies to LEFT, RIGHT and DOWN only. Each of these has its own FSM: IDLE, DELAY, REPEAT, with a 4-bit tick counter.
REQ-023 IDLE -> DELAY on btn_edge; the counter loads 0.
REQ-024 DELAY: each tick with level=1 increments the counter. When the counter reaches DAS_TICKS, the FSM issues one repeat request, loads 0 and goes to REPEAT.
REQ-025 REPEAT: each tick increments the counter. When the counter reaches ARR_TICKS, the FSM issues one repeat request and loads 0.
REQ-026 In DELAY or REPEAT, level=0 sends the FSM to IDLE on the next cycle with the counter at 0; this takes priority over any tick in the same cycle.
REQ-027 A btn_edge arriving in DELAY or REPEAT restarts the FSM in DELAY with counter 0.
REQ-028 ROTATE and DROP never repeat; one press gives at most one command.
REQ-029 A repeat request for a button whose pending flag is already 1 is absorbed, so at most one command is queued per button.

Reset
REQ-030 reset=1 for one clock: cmd_valid=0, cmd_code=0, pending=0, every repeat FSM in IDLE, every counter at 0.
REQ-031 Reset overrides every other input, including a tick or edge in the same cycle.
REQ-032 Reset mid-handshake drops any outstanding command without requiring cmd_ready.

Structure
REQ-033 Package input_pkg holds the button ID constants, the cmd_code constants, and the default DAS_TICKS and ARR_TICKS values.
REQ-034 The repeat FSM is a sub-module named autorepeat, instantiated three times (LEFT, RIGHT, DOWN).
REQ-035 Arbitration, pending flags and the output register live in input_arbiter.

Verification
REQ-036 Single press: ROTATE edge, then tick -> one cycle later cmd_valid=1, cmd_code=3; cmd_ready=1 -> cmd_valid=0 next cycle; pending=0.
REQ-037 Priority and cancel: edges DROP, ROTATE, LEFT, RIGHT in one cycle, cmd_ready tied 1 -> first command 5 on tick 1, second command 3 on tick 2; LEFT and RIGHT cancel; no further commands.
REQ-038 Backpressure: DOWN granted, cmd_ready=0 for 3 ticks, LEFT edge during the stall -> cmd_code holds 4; after ready, the next tick yields 1.
REQ-039 Auto-repeat with DAS_TICKS=8, ARR_TICKS=2: LEFT held for 20 ticks, cmd_ready=1 -> exactly 7 LEFT commands in total (1 press + repeats at tick counts 8, 10, 12, 14, 16, 18); release -> FSM returns to IDLE, no more commands.
REQ-040 Release mid-DELAY: RIGHT held for 5 ticks -> exactly 1 command, no repeat.
REQ-041 Reset mid-operation: cmd_valid=1, pending=5'b11000, reset pulsed one cycle -> all outputs 0 the next cycle; a following tick produces no command.

Source files
------------

// File: rtl/input_pkg.sv
// Shared constants for the input arbiter: button IDs, command codes,
// auto-repeat defaults and the repeat FSM state type.
package input_pkg;

    localparam int NUM_BTN    = 5;
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_DROP   = 4;

    localparam int DAS_TICKS_DEFAULT = 8;
    localparam int ARR_TICKS_DEFAULT = 2;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DOWN   = 3'd4,
        CMD_DROP   = 3'd5
    } cmd_code_t;

    typedef enum logic [1:0] {
        AR_IDLE   = 2'd0,
        AR_DELAY  = 2'd1,
        AR_REPEAT = 2'd2
    } ar_state_t;

endpackage

// File: rtl/input_arbiter_autorepeat.sv
// Per-button auto-repeat FSM. After a press, waits DAS_TICKS ticks with the
// button held, then requests a repeat every ARR_TICKS ticks until release.
// The request is a one-clock pulse raised in the cycle after the counter
// has reached its target.
module autorepeat
    import input_pkg::*;
#(
    parameter int DAS_TICKS = DAS_TICKS_DEFAULT,
    parameter int ARR_TICKS = ARR_TICKS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic press,
    input  logic level,
    output logic repeat_req
);

    ar_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // State and tick counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= AR_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a new press restarts the delay, release beats any tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        repeat_req = 1'b0;
        case (state_q)
            AR_IDLE: begin
                if (press) begin
                    state_d = AR_DELAY;
                    cnt_d   = 4'd0;
                end
            end
            AR_DELAY: begin
                if (press) begin
                    cnt_d = 4'd0;
                end else if (!level) begin
                    state_d = AR_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'(DAS_TICKS)) begin
                    repeat_req = 1'b1;
                    state_d    = AR_REPEAT;
                    cnt_d      = 4'd0;
                end else if (tick) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            AR_REPEAT: begin
                if (press) begin
                    state_d = AR_DELAY;
                    cnt_d   = 4'd0;
                end else if (!level) begin
                    state_d = AR_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'(ARR_TICKS)) begin
                    repeat_req = 1'b1;
                    cnt_d      = 4'd0;
                end else if (tick) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = AR_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/input_arbiter.sv
// Input arbiter: collects button presses and auto-repeats into per-button
// pending flags and, on each input tick, grants one command by fixed
// priority into a registered valid/ready output.
module input_arbiter
    import input_pkg::*;
#(
    parameter int DAS_TICKS = DAS_TICKS_DEFAULT,
    parameter int ARR_TICKS = ARR_TICKS_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick_input,
    input  logic [4:0]   btn_edge,
    input  logic [4:0]   btn_level,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic [2:0]   cmd_code,
    output logic [4:0]   pending
);

    logic [2:0]  rep_req;   // {DOWN, RIGHT, LEFT}
    logic [4:0]  set_mask;
    logic [4:0]  clr_mask;
    logic        can_issue;
    logic        grant_en;
    logic        win_valid;
    cmd_code_t   win_code;
    logic        unused_levels;

    // ROTATE and DROP never repeat, so their levels are not needed.
    assign unused_levels = btn_level[BTN_ROTATE] ^ btn_level[BTN_DROP];

    autorepeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_rep_left (
        .clock(clock), .reset(reset), .tick(tick_input),
        .press(btn_edge[BTN_LEFT]), .level(btn_level[BTN_LEFT]),
        .repeat_req(rep_req[0])
    );

    autorepeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_rep_right (
        .clock(clock), .reset(reset), .tick(tick_input),
        .press(btn_edge[BTN_RIGHT]), .level(btn_level[BTN_RIGHT]),
        .repeat_req(rep_req[1])
    );

    autorepeat #(.DAS_TICKS(DAS_TICKS), .ARR_TICKS(ARR_TICKS)) u_rep_down (
        .clock(clock), .reset(reset), .tick(tick_input),
        .press(btn_edge[BTN_DOWN]), .level(btn_level[BTN_DOWN]),
        .repeat_req(rep_req[2])
    );

    // Output slot is free when empty or being accepted this cycle.
    assign can_issue = !cmd_valid || cmd_ready;
    assign grant_en  = tick_input && can_issue && (|pending);

    // Pending set sources: press edges plus repeat requests.
    always_comb begin
        set_mask           = btn_edge;
        set_mask[BTN_LEFT]  = btn_edge[BTN_LEFT]  | rep_req[0];
        set_mask[BTN_RIGHT] = btn_edge[BTN_RIGHT] | rep_req[1];
        set_mask[BTN_DOWN]  = btn_edge[BTN_DOWN]  | rep_req[2];
    end

    // Fixed-priority winner; LEFT+RIGHT together cancel and let DOWN through.
    always_comb begin
        win_valid = 1'b0;
        win_code  = CMD_NONE;
        clr_mask  = 5'b00000;
        if (grant_en) begin
            if (pending[BTN_DROP]) begin
                win_valid = 1'b1;
                win_code  = CMD_DROP;
                clr_mask[BTN_DROP] = 1'b1;
            end else if (pending[BTN_ROTATE]) begin
                win_valid = 1'b1;
                win_code  = CMD_ROTATE;
                clr_mask[BTN_ROTATE] = 1'b1;
            end else if (pending[BTN_LEFT] && pending[BTN_RIGHT]) begin
                clr_mask[BTN_LEFT]  = 1'b1;
                clr_mask[BTN_RIGHT] = 1'b1;
                if (pending[BTN_DOWN]) begin
                    win_valid = 1'b1;
                    win_code  = CMD_DOWN;
                    clr_mask[BTN_DOWN] = 1'b1;
                end
            end else if (pending[BTN_LEFT]) begin
                win_valid = 1'b1;
                win_code  = CMD_LEFT;
                clr_mask[BTN_LEFT] = 1'b1;
            end else if (pending[BTN_RIGHT]) begin
                win_valid = 1'b1;
                win_code  = CMD_RIGHT;
                clr_mask[BTN_RIGHT] = 1'b1;
            end else if (pending[BTN_DOWN]) begin
                win_valid = 1'b1;
                win_code  = CMD_DOWN;
                clr_mask[BTN_DOWN] = 1'b1;
            end
        end
    end

    // Pending flags (set beats clear) and the held output command register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= 5'b00000;
            cmd_valid <= 1'b0;
            cmd_code  <= 3'd0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            if (can_issue) begin
                cmd_valid <= win_valid;
                cmd_code  <= win_code;
            end
        end
    end

endmodule

// File: tb/tb_input_arbiter.sv
// Scoreboard bench for input_arbiter: stimulus pushes expected command
// codes, a negedge monitor pops one per accepted handshake.
module tb_input_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick_input;
    logic [4:0]  btn_edge;
    logic [4:0]  btn_level;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [4:0]  pending;

    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  mon_exp;

    input_arbiter #(.DAS_TICKS(8), .ARR_TICKS(2)) dut (
        .clock(clock), .reset(reset), .tick_input(tick_input),
        .btn_edge(btn_edge), .btn_level(btn_level), .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pending(pending)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [4:0] e, input logic [4:0] lvl);
        btn_edge  = e;
        btn_level = lvl;
        step();
        btn_edge  = 5'b00000;
    endtask

    task automatic do_tick();
        tick_input = 1'b1;
        step();
        tick_input = 1'b0;
        step();
        step();
    endtask

    // Monitor: every accepted command must match the head of the queue.
    always @(negedge clock) begin
        if (!reset && cmd_valid && cmd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cmd: got code %0d expected none", cmd_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cmd_code !== mon_exp) begin
                    failures++;
                    $display("FAIL cmd_code: got %0d expected %0d", cmd_code, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        tick_input = 1'b0;
        btn_edge   = 5'b00000;
        btn_level  = 5'b00000;
        cmd_ready  = 1'b1;
        step();
        step();
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_code", 32'(cmd_code), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        step();

        // Single ROTATE press
        press(5'b00100, 5'b00000);
        exp_q.push_back(3'd3);
        tick_input = 1'b1;
        step();
        tick_input = 1'b0;
        check("single_valid", 32'(cmd_valid), 32'd1);
        check("single_code", 32'(cmd_code), 32'd3);
        step();
        check("single_drop_valid", 32'(cmd_valid), 32'd0);
        check("single_drop_code", 32'(cmd_code), 32'd0);
        check("single_pending", 32'(pending), 32'd0);
        step();

        // Priority and LEFT/RIGHT cancel
        press(5'b10111, 5'b00000);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd3);
        check("prio_pending0", 32'(pending), 32'b10111);
        do_tick();
        check("prio_pending1", 32'(pending), 32'b00111);
        do_tick();
        check("prio_pending2", 32'(pending), 32'b00011);
        do_tick();
        check("cancel_pending", 32'(pending), 32'd0);
        do_tick();
        do_tick();

        // Backpressure: DOWN held while LEFT arrives
        press(5'b01000, 5'b00000);
        exp_q.push_back(3'd4);
        cmd_ready = 1'b0;
        do_tick();
        check("stall_valid0", 32'(cmd_valid), 32'd1);
        check("stall_code0", 32'(cmd_code), 32'd4);
        do_tick();
        press(5'b00001, 5'b00000);
        exp_q.push_back(3'd1);
        do_tick();
        do_tick();
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_code", 32'(cmd_code), 32'd4);
        check("stall_pending", 32'(pending), 32'b00001);
        cmd_ready = 1'b1;
        do_tick();
        check("stall_after_pending", 32'(pending), 32'd0);
        check("stall_after_valid", 32'(cmd_valid), 32'd0);

        // Auto-repeat: LEFT held for 20 ticks gives 7 commands
        press(5'b00001, 5'b00001);
        for (int i = 0; i < 7; i++) exp_q.push_back(3'd1);
        for (int i = 0; i < 20; i++) begin
            tick_input = 1'b1;
            step();
            tick_input = 1'b0;
            if (i == 19) btn_level = 5'b00000;
            step();
            step();
        end
        repeat (6) do_tick();
        check("repeat_pending", 32'(pending), 32'd0);
        check("repeat_queue", 32'(exp_q.size()), 32'd0);

        // Release mid-delay: RIGHT held for 5 ticks gives 1 command
        press(5'b00010, 5'b00010);
        exp_q.push_back(3'd2);
        for (int i = 0; i < 5; i++) begin
            tick_input = 1'b1;
            step();
            tick_input = 1'b0;
            if (i == 4) btn_level = 5'b00000;
            step();
            step();
        end
        repeat (10) do_tick();
        check("release_pending", 32'(pending), 32'd0);

        // Reset mid-handshake, with tick and edge in the reset cycle
        press(5'b00100, 5'b00000);
        cmd_ready = 1'b0;
        do_tick();
        press(5'b11000, 5'b00000);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        check("pre_rst_pending", 32'(pending), 32'b11000);
        reset      = 1'b1;
        tick_input = 1'b1;
        btn_edge   = 5'b10000;
        step();
        reset      = 1'b0;
        tick_input = 1'b0;
        btn_edge   = 5'b00000;
        check("mid_rst_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_code", 32'(cmd_code), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'd0);
        cmd_ready = 1'b1;
        do_tick();
        check("post_rst_valid", 32'(cmd_valid), 32'd0);
        check("post_rst_pending", 32'(pending), 32'd0);
        step();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
